// File: rtl/i4001_rom_loader_arb_pkg.sv
// Shared types and constants for the i4001 ROM loader/arbiter.
package i4001_rom_loader_arb_pkg;

  localparam int ROM_ADDR_W    = 12;    // byte address: 16 chips x 256 bytes
  localparam int ROM_DATA_W    = 8;     // one ROM byte
  localparam int ROM_SIZE      = 4096;  // total ROM bytes; loads may not cross it
  localparam int DEFAULT_GUARD = 16;    // sysclk cycles of hold before the first write

  // IDLE    : RAM serves the i4001 read path
  // GUARD   : MCS-4 held in POC, waiting for the bus to go quiet
  // LOAD    : loader bytes are written into the RAM
  // RELEASE : hold dropped, completion pulsed
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GUARD   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/i4001_rom_loader_arb_if.sv
// Loader-side control and byte stream of the ROM loader/arbiter.
//
// Handshake: ld_start is a one-cycle pulse; ld_base/ld_len are sampled on
// it. A byte moves on a rising edge where ld_valid & ld_ready are both 1;
// the source holds ld_data stable while ld_valid is 1 and the byte has not
// moved, and ld_ready never depends on ld_valid. ld_abort is a one-cycle
// pulse that ends the load and suppresses any write in that cycle.
// ld_done pulses once per start; ld_err stays set until the next start.
interface i4001_rom_loader_arb_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic [ADDR_W:0]   ld_len;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_abort;
  logic              ld_done;
  logic              ld_err;

  // Loader (source) side
  modport master (
    output ld_start, ld_base, ld_len, ld_valid, ld_data, ld_abort,
    input  ld_ready, ld_done, ld_err
  );

  // ROM loader/arbiter side
  modport slave (
    input  ld_start, ld_base, ld_len, ld_valid, ld_data, ld_abort,
    output ld_ready, ld_done, ld_err
  );
endinterface

// File: rtl/i4001_rom_guard_cnt.sv
// Loadable down-counter with a zero flag; times the hold-before-write window.
module i4001_rom_guard_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over counting; the count parks at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/i4001_rom_loader_arb.sv
// Arbitrates a block RAM between the i4001 ROM read path and a byte loader.
// While idle the RAM answers rom_addr with one cycle of latency; a load
// holds the MCS-4 in POC, waits a guard window, streams bytes into the RAM
// and then releases the system.
module i4001_rom_loader_arb
  import i4001_rom_loader_arb_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W,
  parameter int GUARD  = DEFAULT_GUARD
) (
  input  logic                  sysclk,
  input  logic                  poc_n,
  input  logic [ADDR_W-1:0]     rom_addr,
  output logic [DATA_W-1:0]     rom_data,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  cpu_hold,
  i4001_rom_loader_arb_if.slave ld,
  output state_t                fsm_state
);

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [ADDR_W+1:0] ROM_END = (ADDR_W+2)'(ROM_SIZE);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              guard_load, guard_en, guard_zero;
  logic [ADDR_W+1:0] end_addr;

  // One past the last byte of the requested load; wide enough not to wrap.
  assign end_addr = {2'b00, ld.ld_base} + {1'b0, ld.ld_len};

  i4001_rom_guard_cnt #(
    .W (GW)
  ) u_guard_cnt (
    .clk      (sysclk),
    .rst_n    (poc_n),
    .load     (guard_load),
    .load_val (GW'(GUARD - 1)),
    .en       (guard_en),
    .zero     (guard_zero)
  );

  // State and load bookkeeping registers; reset clears everything mid-load.
  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; starts outside IDLE and aborts outside GUARD/LOAD
  // fall through untouched.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    guard_load = 1'b0;
    guard_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld.ld_start) begin
          if (ld.ld_len == '0) begin
            // Empty load: complete at once, nothing to report.
            done_d = 1'b1;
            err_d  = 1'b0;
          end else if (end_addr > ROM_END) begin
            // Would run past the top of ROM: refuse rather than wrap.
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            addr_d     = ld.ld_base;
            cnt_d      = ld.ld_len;
            err_d      = 1'b0;
            guard_load = 1'b1;
            state_d    = ST_GUARD;
          end
        end
      end
      ST_GUARD: begin
        if (ld.ld_abort) begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end else if (guard_zero) begin
          state_d = ST_LOAD;
        end else begin
          guard_en = 1'b1;
        end
      end
      ST_LOAD: begin
        if (ld.ld_abort) begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end else if (ld.ld_valid) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Writes only happen in LOAD, so they can never occur with the hold low;
  // a reset arriving mid-load also blocks the write of that cycle.
  assign mem_we      = (state_q == ST_LOAD) && ld.ld_valid && !ld.ld_abort && poc_n;
  assign mem_addr    = (state_q == ST_LOAD) ? addr_q : rom_addr;
  assign mem_wdata   = mem_we ? ld.ld_data : '0;
  assign rom_data    = (state_q == ST_IDLE) ? mem_rdata : '0;
  assign cpu_hold    = (state_q == ST_GUARD) || (state_q == ST_LOAD);
  assign ld.ld_ready = (state_q == ST_LOAD);
  assign ld.ld_done  = done_q || (state_q == ST_RELEASE);
  assign ld.ld_err   = err_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_i4001_rom_loader_arb.sv
// Bench for the i4001 ROM loader/arbiter: block-RAM model, loader driver,
// write monitor and a transaction-level scoreboard.
module tb_i4001_rom_loader_arb;
  import i4001_rom_loader_arb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int GUARD = 16;
  localparam int W = AW + DW;

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  logic poc_n;
  always #5 sysclk = ~sysclk;

  logic [AW-1:0] rom_addr, mem_addr;
  logic [DW-1:0] rom_data, mem_wdata, mem_rdata;
  logic          mem_we, cpu_hold;
  state_t        fsm_state;

  i4001_rom_loader_arb_if #(.ADDR_W(AW), .DATA_W(DW)) ld ();

  i4001_rom_loader_arb #(.ADDR_W(AW), .DATA_W(DW), .GUARD(GUARD)) dut (
    .sysclk    (sysclk),
    .poc_n     (poc_n),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .cpu_hold  (cpu_hold),
    .ld        (ld),
    .fsm_state (fsm_state)
  );

  // ---------------- block RAM model with a backdoor write port ----------------
  logic [DW-1:0] ram [0:4095];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  always @(posedge sysclk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (bd_we) ram[bd_addr] <= bd_data;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] ref_mem [0:4095];
  logic [DW-1:0] tx_data[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int           cyc_n = 0;
  int           done_cnt = 0;
  int           hold_rises = 0;
  int           hold_rise_cyc = 0;
  bit           hold_prev = 1'b0;
  logic [W-1:0] obs_q[$];
  int           obs_cyc_q[$];
  always @(negedge sysclk) begin
    cyc_n++;
    if (mem_we === 1'b1) begin
      obs_q.push_back({mem_addr, mem_wdata});
      obs_cyc_q.push_back(cyc_n);
      check("we_hold", cpu_hold, 1);
      check("we_valid", ld.ld_valid, 1);
    end
    if (ld.ld_done === 1'b1) done_cnt++;
    if (cpu_hold && !hold_prev) begin
      hold_rises++;
      hold_rise_cyc = cyc_n;
    end
    hold_prev = cpu_hold;
  end

  // ---------------- driver tasks ----------------
  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge sysclk); #1;
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge sysclk); #1;
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic read_check(input logic [AW-1:0] a);
    @(posedge sysclk); #1;
    rom_addr = a;
    @(posedge sysclk);
    @(negedge sysclk);
    check("rom_data", rom_data, ref_mem[a]);
    check("read_we", mem_we, 0);
  endtask

  // mode: 0 = valid held, 1 = valid every other cycle, 2 = random valid.
  // abort_after: number of bytes accepted before ld_abort, -1 for none.
  task automatic run_load(input logic [AW-1:0] base, input int len, input int mode,
                          input int abort_after, input bit spurious);
    int done0, rise0, obs0, n_exp, cyc, sent, budget;
    bit ovf, exp_err, exp_hold, aborted, fin, v;
    done0 = done_cnt; rise0 = hold_rises; obs0 = obs_q.size();
    while (tx_data.size() < len) tx_data.push_back(DW'($urandom_range(0, 255)));
    // Reference: what the load should do, from the block's rules.
    ovf      = (int'(base) + len > ROM_SIZE);
    exp_hold = (len > 0) && !ovf;
    n_exp    = !exp_hold ? 0 : ((abort_after >= 0 && abort_after < len) ? abort_after : len);
    exp_err  = ovf || (exp_hold && abort_after >= 0 && abort_after < len);
    exp_q.delete();
    for (int i = 0; i < n_exp; i++) exp_q.push_back({base + AW'(i), tx_data[i]});
    budget = GUARD + 4 * len + 40;

    @(posedge sysclk); #1;
    ld.ld_start = 1'b1; ld.ld_base = base; ld.ld_len = (AW+1)'(len);
    @(posedge sysclk); #1;
    ld.ld_start = 1'b0;
    cyc = 0; sent = 0; aborted = 1'b0; fin = 1'b0;
    while (!fin && cyc < budget) begin
      ld.ld_abort = 1'b0;
      if (!aborted && abort_after >= 0 && abort_after < len && sent == abort_after &&
          (ld.ld_ready || (abort_after == 0 && cyc == 3))) begin
        ld.ld_abort = 1'b1;
        aborted = 1'b1;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      ld.ld_valid = (aborted && !ld.ld_abort) ? 1'b0 : ((sent < len) ? v : 1'b0);
      ld.ld_data  = (sent < len) ? tx_data[sent] : '0;
      ld.ld_start = spurious && (cyc == GUARD + 1) && cpu_hold && !ld.ld_abort;
      if (ld.ld_start) begin
        ld.ld_base = ~base;
        ld.ld_len  = (AW+1)'(1);
      end
      @(negedge sysclk); #1;
      if (cyc == 0) check("err_start", ld.ld_err, ovf);
      if (ld.ld_ready && ld.ld_valid && !ld.ld_abort) sent++;
      if (ld.ld_done) fin = 1'b1;
      cyc++;
      @(posedge sysclk); #1;
    end
    ld.ld_valid = 1'b0; ld.ld_abort = 1'b0; ld.ld_start = 1'b0;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk); #1;

    check("timeout", fin, 1);
    check("done_pulses", done_cnt - done0, 1);
    check("hold_rises", hold_rises - rise0, exp_hold);
    check("n_writes", obs_q.size() - obs0, n_exp);
    for (int i = 0; i < n_exp; i++)
      if (obs0 + i < obs_q.size()) check("wr_addr_data", obs_q[obs0 + i], exp_q[i]);
    if (mode == 0 && n_exp > 0 && obs_q.size() > obs0)
      check("guard_gap", obs_cyc_q[obs0] - hold_rise_cyc, GUARD);
    check("err_end", ld.ld_err, exp_err);
    check("hold_end", cpu_hold, 0);
    check("ready_end", ld.ld_ready, 0);
    check("state_end", fsm_state, ST_IDLE);

    for (int i = 0; i < n_exp; i++) ref_mem[base + AW'(i)] = tx_data[i];
    tx_data.delete();
    if (n_exp > 0) begin
      read_check(base);
      read_check(base + AW'(n_exp - 1));
    end
  endtask

  task automatic reset_mid_load();
    int obs0, n_at, k;
    obs0 = obs_q.size();
    @(posedge sysclk); #1;
    ld.ld_start = 1'b1; ld.ld_base = 12'h200; ld.ld_len = 13'd8;
    @(posedge sysclk); #1;
    ld.ld_start = 1'b0; ld.ld_valid = 1'b1; ld.ld_data = 8'hA5;
    k = 0;
    while (obs_q.size() - obs0 < 3 && k < GUARD + 20) begin
      @(posedge sysclk); #1;
      k++;
    end
    check("rst_reach_load", (obs_q.size() - obs0 >= 3), 1);
    poc_n = 1'b0;
    n_at = obs_q.size();
    @(posedge sysclk);
    @(negedge sysclk); #1;
    check("rst_state", fsm_state, ST_IDLE);
    check("rst_hold", cpu_hold, 0);
    check("rst_we", mem_we, 0);
    check("rst_ready", ld.ld_ready, 0);
    check("rst_done", ld.ld_done, 0);
    check("rst_err", ld.ld_err, 0);
    @(posedge sysclk); #1;
    poc_n = 1'b1;
    repeat (5) @(posedge sysclk);
    #1;
    check("rst_nowrite", obs_q.size(), n_at);
    ld.ld_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    poc_n = 1'b0;
    rom_addr = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    ld.ld_start = 1'b0; ld.ld_base = '0; ld.ld_len = '0;
    ld.ld_valid = 1'b0; ld.ld_data = '0; ld.ld_abort = 1'b0;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    check("reset_state", fsm_state, ST_IDLE);
    check("reset_hold", cpu_hold, 0);
    check("reset_we", mem_we, 0);
    check("reset_ready", ld.ld_ready, 0);
    check("reset_done", ld.ld_done, 0);
    check("reset_err", ld.ld_err, 0);
    @(posedge sysclk); #1;
    poc_n = 1'b1;

    // Read path
    bd_write(12'h1A3, 8'h5C);
    read_check(12'h1A3);
    for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 4095));
      bd_write(a, DW'($urandom_range(0, 255)));
      read_check(a);
    end

    // Directed loads
    tx_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(12'h0FE, 4, 0, -1, 1'b0);   // crosses a chip boundary
    run_load(12'hFFF, 2, 0, -1, 1'b0);   // past top of ROM: refused
    run_load(12'h010, 0, 0, -1, 1'b0);   // empty load
    run_load(12'hFFC, 4, 0, -1, 1'b0);   // ends exactly at the top
    run_load(12'h300, 3, 1, -1, 1'b0);   // gappy valid
    run_load(12'h400, 5, 0, 2, 1'b0);    // abort after 2 bytes
    run_load(12'h410, 1, 0, -1, 1'b0);   // next start clears the error
    run_load(12'h500, 3, 0, 0, 1'b0);    // abort during guard
    run_load(12'h600, 6, 0, -1, 1'b1);   // stray start mid-load
    reset_mid_load();

    // Random loads
    for (int t = 0; t < 10; t++) begin
      int len, mode, ab;
      logic [AW-1:0] base;
      len  = int'($urandom_range(0, 6));
      base = ($urandom_range(0, 3) == 0) ? AW'(ROM_SIZE - int'($urandom_range(1, 5)))
                                         : AW'($urandom_range(0, 4095));
      mode = int'($urandom_range(0, 2));
      ab   = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_load(base, len, mode, ab, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Run-away guard
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
